// File: rtl/fstage_bus.sv
// Instruction-fetch stage: one AXI4-Lite read per round, handshake to decode, then wait for next PC.
// Optional macro FETCH_RRESP_CHECK_EN: a non-OKAY rresp parks the FSM in ERR with a sticky fetch_err.
module fstage_bus #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] dnpc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_AR       = 3'd1,
        S_R        = 3'd2,
        S_OUT      = 3'd3,
        S_WAIT_NPC = 3'd4
`ifdef FETCH_RRESP_CHECK_EN
        ,
        S_ERR      = 3'd5
`endif
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        arvalid_r;
    logic        rready_r;
    logic        m_valid_r;
    logic        s_ready_r;
    logic        unused_s;

    // Next-state decode; inputs outside their owning state are ignored.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_BOOT: begin
                state_next_s = S_AR;
            end
            S_AR: begin
                if (arready) state_next_s = S_R;
                else         state_next_s = S_AR;
            end
            S_R: begin
                if (rvalid) begin
`ifdef FETCH_RRESP_CHECK_EN
                    if (rresp != 2'b00) state_next_s = S_ERR;
                    else                state_next_s = S_OUT;
`else
                    state_next_s = S_OUT;
`endif
                end else begin
                    state_next_s = S_R;
                end
            end
            S_OUT: begin
                if (m_ready) state_next_s = S_WAIT_NPC;
                else         state_next_s = S_OUT;
            end
            S_WAIT_NPC: begin
                if (s_valid) state_next_s = S_AR;
                else         state_next_s = S_WAIT_NPC;
            end
`ifdef FETCH_RRESP_CHECK_EN
            S_ERR: begin
                state_next_s = S_ERR;
            end
`endif
            default: begin
                state_next_s = S_BOOT;
            end
        endcase
    end

    // State register with handshake outputs registered from the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_BOOT;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            arvalid_r <= (state_next_s == S_AR);
            rready_r  <= (state_next_s == S_R);
            m_valid_r <= (state_next_s == S_OUT);
            s_ready_r <= (state_next_s == S_WAIT_NPC);
        end
    end

    // PC and instruction capture on their respective handshakes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r   <= RESET_PC;
            inst_r <= 32'h0000_0000;
        end else begin
            if ((state_r == S_WAIT_NPC) && s_valid) pc_r <= {dnpc[31:2], 2'b00};
            if ((state_r == S_R) && rvalid)         inst_r <= rdata;
        end
    end

`ifdef FETCH_RRESP_CHECK_EN
    logic err_r;

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_r <= 1'b0;
        else      err_r <= (state_next_s == S_ERR);
    end

    assign fetch_err = err_r;
    assign unused_s  = ^dnpc[1:0];
`else
    assign fetch_err = 1'b0;
    assign unused_s  = ^{dnpc[1:0], rresp};
`endif

    assign instF   = inst_r;
    assign pcF     = pc_r;
    assign araddr  = pc_r;
    assign snpcF   = pc_r + 32'd4;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;
    assign m_valid = m_valid_r;
    assign s_ready = s_ready_r;

endmodule

// File: tb/tb_fstage_bus.sv
// Directed, table-driven bench for fstage_bus; honours FETCH_RRESP_CHECK_EN for the rresp case.
module tb_fstage_bus;

    logic        clk;
    logic        rst;
    logic [31:0] instF, pcF, snpcF, araddr, dnpc, rdata;
    logic        m_valid, m_ready, s_valid, s_ready;
    logic        arvalid, arready, rvalid, rready, fetch_err;
    logic [1:0]  rresp;

    int checks;
    int errors;

    fstage_bus dut (
        .clk(clk), .rst(rst),
        .instF(instF), .pcF(pcF), .snpcF(snpcF),
        .m_valid(m_valid), .m_ready(m_ready),
        .s_valid(s_valid), .s_ready(s_ready), .dnpc(dnpc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arready;
        logic        rvalid;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        logic        m_ready;
        logic        s_valid;
        logic [31:0] dnpc;
        logic [3:0]  exp_ctl;   // {arvalid, rready, m_valid, s_ready}
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ar, input logic rv, input logic [1:0] rr, input logic [31:0] rd,
                         input logic mr, input logic sv, input logic [31:0] np);
        arready = ar; rvalid = rv; rresp = rr; rdata = rd;
        m_ready = mr; s_valid = sv; dnpc = np;
    endtask

    task automatic chk_outputs(input string tag, input logic [3:0] ctl, input logic [31:0] pc,
                               input logic [31:0] inst, input logic err);
        chk({tag, ".ctl"},   {28'd0, arvalid, rready, m_valid, s_ready}, {28'd0, ctl});
        chk({tag, ".araddr"}, araddr, pc);
        chk({tag, ".pcF"},    pcF, pc);
        chk({tag, ".snpcF"},  snpcF, pc + 32'd4);
        chk({tag, ".instF"},  instF, inst);
        chk({tag, ".err"},    {31'd0, fetch_err}, {31'd0, err});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);

        // BOOT, zero-wait fetch; inputs of other states held high to show they are ignored
        vecs.push_back('{1'b1, 1'b1, 2'b00, 32'h0000_0413, 1'b1, 1'b1, 32'h0, 4'b0000, 32'h8000_0000, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 32'h0000_0413, 1'b1, 1'b1, 32'h0, 4'b1000, 32'h8000_0000, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 32'h0000_0413, 1'b0, 1'b1, 32'h0, 4'b0100, 32'h8000_0000, 32'h0});
        // back-pressure: five OUT cycles with m_ready low, stray rvalid/s_valid
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h1234_5678, 4'b0010, 32'h8000_0000, 32'h0000_0413});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0010, 32'h8000_0000, 32'h0000_0413});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0001, 32'h8000_0000, 32'h0000_0413});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h8000_0102, 4'b0001, 32'h8000_0000, 32'h0000_0413});
        // wait states: arready 3 cycles late, rvalid 2 cycles late
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 4'b1000, 32'h8000_0100, 32'h0000_0413});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'b1000, 32'h8000_0100, 32'h0000_0413});
        for (int i = 0; i < 2; i++)
            vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0100, 32'h8000_0100, 32'h0000_0413});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 32'h0010_0093, 1'b0, 1'b0, 32'h0, 4'b0100, 32'h8000_0100, 32'h0000_0413});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0010, 32'h8000_0100, 32'h0010_0093});
        // wrap-around PC
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'b0001, 32'h8000_0100, 32'h0010_0093});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'b1000, 32'hFFFF_FFFC, 32'h0010_0093});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 4'b0100, 32'hFFFF_FFFC, 32'h0010_0093});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0010, 32'hFFFF_FFFC, 32'h1234_5678});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h8000_0200, 4'b0001, 32'hFFFF_FFFC, 32'h1234_5678});
        // error-response fetch; the outcome is checked by hand below
        vecs.push_back('{1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'b1000, 32'h8000_0200, 32'h1234_5678});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 4'b0100, 32'h8000_0200, 32'h1234_5678});

        // reset values while rst is held low
        next_cycle();
        next_cycle();
        chk_outputs("reset", 4'b0000, 32'h8000_0000, 32'h0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].arready, vecs[i].rvalid, vecs[i].rresp, vecs[i].rdata,
                  vecs[i].m_ready, vecs[i].s_valid, vecs[i].dnpc);
            chk_outputs($sformatf("vec%0d", i), vecs[i].exp_ctl, vecs[i].exp_pc, vecs[i].exp_inst, 1'b0);
            next_cycle();
        end

        // after the rresp=2'b10 beat: all other-state inputs asserted, nothing may move
        drive(1'b1, 1'b1, 2'b00, 32'h5555_AAAA, 1'b1, 1'b1, 32'h8000_0400);
`ifdef FETCH_RRESP_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            chk_outputs($sformatf("err%0d", i), 4'b0000, 32'h8000_0200, 32'hBAD0_BAD0, 1'b1);
            next_cycle();
        end
`else
        chk_outputs("noerr", 4'b0010, 32'h8000_0200, 32'hBAD0_BAD0, 1'b0);
        next_cycle();
        chk_outputs("noerr_wait", 4'b0001, 32'h8000_0200, 32'hBAD0_BAD0, 1'b0);
        next_cycle();
`endif

        // asynchronous reset while in R
        rst = 1'b0;
        next_cycle();
        drive(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        chk_outputs("pre_async", 4'b0100, 32'h8000_0000, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_outputs("async_rst", 4'b0000, 32'h8000_0000, 32'h0, 1'b0);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 1'b1, 2'b00, 32'h0000_0513, 1'b0, 1'b0, 32'h0);
        chk_outputs("restart_boot", 4'b0000, 32'h8000_0000, 32'h0, 1'b0);
        next_cycle();
        chk_outputs("restart_ar", 4'b1000, 32'h8000_0000, 32'h0, 1'b0);
        next_cycle();
        chk_outputs("restart_r", 4'b0100, 32'h8000_0000, 32'h0, 1'b0);
        next_cycle();
        chk_outputs("restart_out", 4'b0010, 32'h8000_0000, 32'h0000_0513, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fstage_bus.md
# fstage_bus

Instruction-fetch stage of the multi-cycle core. Holds the PC, fetches one 32-bit instruction per round over an AXI4-Lite read channel, and presents `instF`/`pcF`/`snpcF` to the decode stage with a valid/ready handshake. It then waits for the next PC (`dnpc`) from the write-back side before starting the next fetch. Only one instruction is in flight at a time.

## Interface
- `RESET_PC`, 32'h80000000, address of the first fetch after reset.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `instF`  out  32  fetched instruction.
- `pcF`  out  32  address of `instF`.
- `snpcF`  out  32  `pcF + 4`, combinational, wraps modulo 2^32.
- `m_valid`  out  1  instruction valid to decode.
- `m_ready`  in  1  decode accepts.
- `s_valid`  in  1  next PC offered by write-back.
- `s_ready`  out  1  fetch accepts next PC.
- `dnpc`  in  32  next PC, sampled on the `s_valid & s_ready` edge.
- `araddr`  out  32  read address, equals `pcF`.
- `arvalid`  out  1  AXI read-address valid.
- `arready`  in  1  AXI read-address ready.
- `rdata`  in  32  AXI read data.
- `rresp`  in  2  AXI read response.
- `rvalid`  in  1  AXI read-data valid.
- `rready`  out  1  AXI read-data ready.
- `fetch_err`  out  1  sticky fetch-error flag.

## Operation
- FSM states: BOOT, AR, R, OUT, WAIT_NPC, ERR.
- BOOT: all valids and readies are 0. Goes to AR unconditionally on the first edge after reset release.
- AR: `arvalid=1`, `araddr=pcF`. Goes to R on `arvalid & arready`.
- R: `rready=1`. On `rvalid`, `instF <= rdata` and the FSM goes to OUT, or to ERR (see Configuration).
- OUT: `m_valid=1`. `instF`, `pcF` and `snpcF` are held stable. Goes to WAIT_NPC on `m_ready`.
- WAIT_NPC: `s_ready=1`. On `s_valid`, `pcF <= {dnpc[31:2],2'b00}` (low bits forced to 0) and the FSM goes to AR.
- ERR: all valids and readies are 0, `fetch_err=1`. Only reset leaves ERR.
- Each valid/ready output is a pure decode of the FSM state. No output is combinationally driven from an input.
- `m_ready` outside OUT, `s_valid` outside WAIT_NPC, and `rvalid` outside R are all ignored. The master may hold them without effect.
- AXI rules: `arvalid` never drops before `arready`, and `araddr` is stable while `arvalid=1`.

## Timing
- Reset values:
  - state = BOOT.
  - `pcF = RESET_PC`, `snpcF = RESET_PC+4`, `instF = 0`.
  - `arvalid`, `rready`, `m_valid`, `s_ready`, `fetch_err` = 0.
- Reset asserted mid-fetch (any state) takes effect immediately and returns the FSM to BOOT. A pending AXI response is abandoned, and the memory model is reset together with this block.
- First `arvalid` is high in the second cycle after reset release (BOOT occupies one cycle).
- Zero-wait memory (`arready`, `rvalid` both high):
  - `s_valid&s_ready` at edge N → `arvalid` in cycle N+1, `rready` in N+2, `m_valid` in N+3.
- Each wait cycle of `arready` or `rvalid` adds one cycle.
- Handshakes complete on the edge where valid and ready are both 1. The state leaves at that edge.
- `dnpc` = 32'hFFFFFFFC: fetch at that address; `snpcF` wraps to 0.

## Configuration
- Macro `FETCH_RRESP_CHECK_EN`.
- Defined:
  - In R, `rvalid` with `rresp != 2'b00` goes to ERR instead of OUT.
  - `instF` still latches `rdata`, and `pcF` holds the faulting address.
  - `fetch_err` stays 1 until reset.
- Undefined:
  - `rresp` is ignored and R always goes to OUT.
  - `fetch_err` is tied to 0 and the ERR state is not implemented.

## Test plan
- Reset release, zero-wait memory returning 32'h00000413:
  - `arvalid` rises the second cycle after release with `araddr` = 32'h80000000.
  - `m_valid` rises 2 cycles later, with `instF` = 32'h00000413, `pcF` = 32'h80000000, `snpcF` = 32'h80000004.
- Back-pressure with `m_ready=0` for 5 cycles:
  - `m_valid` stays 1 and outputs are unchanged.
  - On `m_ready=1`, the next cycle has `m_valid=0` and `s_ready=1`.
- Memory wait states: `arready` delayed 3 cycles and `rvalid` delayed 2 cycles.
  - `araddr` is stable throughout.
  - `m_valid` appears 5 cycles later than the zero-wait case.
- Next-PC path:
  - `dnpc` = 32'h80000102 accepted → next `araddr` = 32'h80000100.
  - `dnpc` = 32'hFFFFFFFC → `snpcF` = 32'h00000000.
- With `FETCH_RRESP_CHECK_EN`: `rresp` = 2'b10 → `fetch_err=1`, `m_valid` never rises, and later `s_valid`/`rvalid` are ignored until reset. Without the macro, the same stimulus delivers `instF` normally.
- Reset asserted while in R: all outputs return to reset values asynchronously. After release, the fetch restarts at `RESET_PC`.
